// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial sequence detector with masked runtime pattern
//
// Shifts in one qualified serial bit per clock and compares the most recent
// PAT_W bits against a loadable pattern. A per-bit mask marks which pattern
// bits are compared. Overlapping and non-overlapping match modes are
// supported. The match flag is a registered one-cycle pulse.
//
// Optional feature macro: SEQDET_MATCH_CNT_EN
//   defined   : a CNT_W-bit saturating match counter drives matchCount
//   undefined : matchCount is tied to zero and cntClr is ignored
//
// Parameters:
//   PAT_W    pattern length in bits (2..32)
//   PATTERN  pattern restored on reset, MSB is the first-received bit
//   CNT_W    match counter width (1..32)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   serIn        in   serial data bit
//   serInValid   in   qualifies serIn
//   overlap      in   1 = overlapping matches, 0 = non-overlapping
//   patLoad      in   load patIn/patMask and restart detection
//   patIn        in   new pattern (PAT_W bits)
//   patMask      in   compare mask, 1 = compare, 0 = don't care
//   cntClr       in   clear the match counter (wins over a same-edge match)
//   serOutValid  out  registered one-cycle match pulse
//   matchCount   out  saturating match count (CNT_W bits)

module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  input  logic             serInValid,
  input  logic             overlap,
  input  logic             patLoad,
  input  logic [PAT_W-1:0] patIn,
  input  logic [PAT_W-1:0] patMask,
  input  logic             cntClr,
  output logic             serOutValid,
  output logic [CNT_W-1:0] matchCount
);

  // fill must be able to hold the value PAT_W itself
  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // one bit short of a full window: the incoming bit completes it
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-1:0]  mask_q,  mask_d;
  logic [PAT_W-1:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic              match_q, match_d;

  logic [PAT_W-1:0]  nxt;
  logic              window_full;
  logic              pat_equal;
  logic              hit;

  // Candidate window including the bit arriving on this edge.
  assign nxt         = {hist_q[PAT_W-2:0], serIn};
  assign window_full = (fill_q >= FILL_THR);
  assign pat_equal   = (((nxt ^ pat_q) & mask_q) == '0);
  assign hit         = serInValid && !patLoad && window_full && pat_equal;

  // The oldest history bit is shifted out without ever being compared; the
  // comparison always uses the window formed with the new bit.
  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[PAT_W-1];

  always_comb begin
    pat_d   = pat_q;
    mask_d  = mask_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;

    if (patLoad) begin
      // A pattern load restarts detection; any serIn this cycle is dropped.
      pat_d  = patIn;
      mask_d = patMask;
      hist_d = '0;
      fill_d = '0;
    end else if (serInValid) begin
      hist_d = nxt;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      if (hit) begin
        match_d = 1'b1;
        // Non-overlapping mode demands PAT_W fresh bits before the next match.
        fill_d  = overlap ? FILL_MAX : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PATTERN;
      mask_q  <= '1;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign serOutValid = match_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats a same-edge match; the count saturates at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cntClr) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign matchCount = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cntClr;
  assign matchCount     = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param

module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;

`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             serIn;
  logic             serInValid;
  logic             overlap;
  logic             patLoad;
  logic [PAT_W-1:0] patIn;
  logic [PAT_W-1:0] patMask;
  logic             cntClr;
  logic             serOutValid;
  logic [CNT_W-1:0] matchCount;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(
    .PAT_W  (PAT_W),
    .PATTERN(4'b1011),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serIn      (serIn),
    .serInValid (serInValid),
    .overlap    (overlap),
    .patLoad    (patLoad),
    .patIn      (patIn),
    .patMask    (patMask),
    .cntClr     (cntClr),
    .serOutValid(serOutValid),
    .matchCount (matchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ec(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; serInValid = 1'b0; patLoad = 1'b0; cntClr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Accept one bit, then check the registered pulse for that edge.
  task automatic bit_chk(input logic b, input logic exp_pulse, input string tag);
    serIn = b; serInValid = 1'b1;
    tick();
    serInValid = 1'b0;
    chk(tag, 32'(serOutValid), 32'(exp_pulse));
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m);
    patIn = p; patMask = m; patLoad = 1'b1;
    serIn = 1'b1; serInValid = 1'b1;
    tick();
    patLoad = 1'b0; serInValid = 1'b0;
    chk("load_no_pulse", 32'(serOutValid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; serIn = 1'b0; serInValid = 1'b0; overlap = 1'b1;
    patLoad = 1'b0; patIn = '0; patMask = '0; cntClr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_sov", 32'(serOutValid), 32'd0);
    chk("reset_cnt", 32'(matchCount), 32'd0);

    // Basic match on 1,0,1,1
    overlap = 1'b1;
    bit_chk(1'b1, 1'b0, "basic_b1");
    bit_chk(1'b0, 1'b0, "basic_b2");
    bit_chk(1'b1, 1'b0, "basic_b3");
    bit_chk(1'b1, 1'b1, "basic_b4");
    chk("basic_cnt", 32'(matchCount), ec(1));
    tick();
    chk("basic_pulse_one_cycle", 32'(serOutValid), 32'd0);

    // Overlapping: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7
    do_reset();
    overlap = 1'b1;
    bit_chk(1'b1, 1'b0, "ovl_b1");
    bit_chk(1'b0, 1'b0, "ovl_b2");
    bit_chk(1'b1, 1'b0, "ovl_b3");
    bit_chk(1'b1, 1'b1, "ovl_b4");
    bit_chk(1'b0, 1'b0, "ovl_b5");
    bit_chk(1'b1, 1'b0, "ovl_b6");
    bit_chk(1'b1, 1'b1, "ovl_b7");
    chk("ovl_cnt", 32'(matchCount), ec(2));

    // Non-overlapping: same stream, one pulse only
    do_reset();
    overlap = 1'b0;
    bit_chk(1'b1, 1'b0, "novl_b1");
    bit_chk(1'b0, 1'b0, "novl_b2");
    bit_chk(1'b1, 1'b0, "novl_b3");
    bit_chk(1'b1, 1'b1, "novl_b4");
    bit_chk(1'b0, 1'b0, "novl_b5");
    bit_chk(1'b1, 1'b0, "novl_b6");
    bit_chk(1'b1, 1'b0, "novl_b7");
    chk("novl_cnt", 32'(matchCount), ec(1));

    // Valid gaps with serIn toggling while invalid
    do_reset();
    overlap = 1'b1;
    bit_chk(1'b1, 1'b0, "gap_b1");
    bit_chk(1'b0, 1'b0, "gap_b2");
    for (int i = 0; i < 3; i++) begin
      serIn = ~serIn; serInValid = 1'b0;
      tick();
      chk("gap_idle", 32'(serOutValid), 32'd0);
    end
    bit_chk(1'b1, 1'b0, "gap_b3");
    bit_chk(1'b1, 1'b1, "gap_b4");
    chk("gap_cnt", 32'(matchCount), ec(1));

    // Load 0110 with mask 1001
    do_reset();
    overlap = 1'b0;
    load(4'b0110, 4'b1001);
    bit_chk(1'b0, 1'b0, "ld_b1");
    bit_chk(1'b1, 1'b0, "ld_b2");
    bit_chk(1'b1, 1'b0, "ld_b3");
    bit_chk(1'b0, 1'b1, "ld_b4");
    bit_chk(1'b0, 1'b0, "ldz_b1");
    bit_chk(1'b0, 1'b0, "ldz_b2");
    bit_chk(1'b0, 1'b0, "ldz_b3");
    bit_chk(1'b0, 1'b1, "ldz_b4");
    chk("ld_cnt", 32'(matchCount), ec(2));
    // Reload after 3 bits restarts the window
    bit_chk(1'b0, 1'b0, "reld_pre1");
    bit_chk(1'b1, 1'b0, "reld_pre2");
    bit_chk(1'b1, 1'b0, "reld_pre3");
    load(4'b0110, 4'b1001);
    bit_chk(1'b0, 1'b0, "reld_b1");
    bit_chk(1'b1, 1'b0, "reld_b2");
    bit_chk(1'b1, 1'b0, "reld_b3");
    bit_chk(1'b0, 1'b1, "reld_b4");

    // Reset mid-stream restores 1011 and drops the partial sequence
    bit_chk(1'b1, 1'b0, "rstm_pre1");
    bit_chk(1'b0, 1'b0, "rstm_pre2");
    bit_chk(1'b1, 1'b0, "rstm_pre3");
    do_reset();
    chk("rstm_cnt", 32'(matchCount), 32'd0);
    bit_chk(1'b1, 1'b0, "rstm_b1");
    bit_chk(1'b0, 1'b0, "rstm_b2");
    bit_chk(1'b1, 1'b0, "rstm_b3");
    bit_chk(1'b1, 1'b1, "rstm_b4");

    // All don't-care mask: back-to-back matches from the 4th bit on
    do_reset();
    overlap = 1'b1;
    load(4'b0000, 4'b0000);
    bit_chk(1'b1, 1'b0, "dc_b1");
    bit_chk(1'b0, 1'b0, "dc_b2");
    bit_chk(1'b1, 1'b0, "dc_b3");
    bit_chk(1'b0, 1'b1, "dc_b4");
    bit_chk(1'b1, 1'b1, "dc_b5");
    chk("dc_cnt", 32'(matchCount), ec(2));

    // Saturation with CNT_W=2: five overlapping matches
    do_reset();
    overlap = 1'b1;
    bit_chk(1'b1, 1'b0, "sat_b1");
    bit_chk(1'b0, 1'b0, "sat_b2");
    bit_chk(1'b1, 1'b0, "sat_b3");
    bit_chk(1'b1, 1'b1, "sat_m1");
    chk("sat_cnt1", 32'(matchCount), ec(1));
    for (int m = 2; m <= 5; m++) begin
      bit_chk(1'b0, 1'b0, "sat_x0");
      bit_chk(1'b1, 1'b0, "sat_x1");
      bit_chk(1'b1, 1'b1, "sat_match");
      chk("sat_cnt", 32'(matchCount), ec((m > 3) ? 3 : m));
    end
    // Clear coincident with sixth match
    bit_chk(1'b0, 1'b0, "clr_x0");
    bit_chk(1'b1, 1'b0, "clr_x1");
    cntClr = 1'b1;
    bit_chk(1'b1, 1'b1, "clr_match_pulse");
    cntClr = 1'b0;
    chk("clr_cnt", 32'(matchCount), 32'd0);
    tick();
    chk("clr_after_sov", 32'(serOutValid), 32'd0);
    chk("clr_after_cnt", 32'(matchCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
